// File: rtl/spu_pkg.sv
// Shared opcodes, instruction field positions, memory sizes and vector helpers for the SPU core.
package spu_pkg;
  localparam int IMEM_WORDS = 1024;
  localparam int NUM_REGS   = 128;
  localparam int LS_LINES   = 128;
  localparam int VEC_W      = 128;
  localparam int NUM_WORDS  = 4;

  // Little-endian positions of big-endian instruction fields.
  localparam int OP11_LSB = 21;
  localparam int OP9_LSB  = 23;
  localparam int OP8_LSB  = 24;
  localparam int RB_LSB   = 14;
  localparam int RA_LSB   = 7;
  localparam int RT_LSB   = 0;

  localparam logic [10:0] OP_A    = 11'b00011000000;
  localparam logic [10:0] OP_SF   = 11'b00001000000;
  localparam logic [10:0] OP_AND  = 11'b00011000001;
  localparam logic [10:0] OP_OR   = 11'b00001000001;
  localparam logic [10:0] OP_XOR  = 11'b01001000001;
  localparam logic [10:0] OP_NOP  = 11'b01000000001;
  localparam logic [10:0] OP_STOP = 11'b00000000000;
  localparam logic [8:0]  OP_IL   = 9'b010000001;
  localparam logic [8:0]  OP_BR   = 9'b001100100;
  localparam logic [8:0]  OP_BRZ  = 9'b001000000;
  localparam logic [7:0]  OP_AI   = 8'b00011100;
  localparam logic [7:0]  OP_LQD  = 8'b00110100;
  localparam logic [7:0]  OP_STQD = 8'b00100100;

  typedef enum logic [3:0] {
    U_NOP, U_A, U_SF, U_AND, U_OR, U_XOR, U_STOP,
    U_IL, U_BR, U_BRZ, U_AI, U_LQD, U_STQD
  } uop_e;

  // Longest opcode wins; anything unmatched falls through to nop.
  function automatic uop_e decode(input logic [31:0] ins);
    uop_e u;
    u = U_NOP;
    case (ins[31:OP11_LSB])
      OP_A:    u = U_A;
      OP_SF:   u = U_SF;
      OP_AND:  u = U_AND;
      OP_OR:   u = U_OR;
      OP_XOR:  u = U_XOR;
      OP_NOP:  u = U_NOP;
      OP_STOP: u = U_STOP;
      default:
        case (ins[31:OP9_LSB])
          OP_IL:  u = U_IL;
          OP_BR:  u = U_BR;
          OP_BRZ: u = U_BRZ;
          default:
            case (ins[31:OP8_LSB])
              OP_AI:   u = U_AI;
              OP_LQD:  u = U_LQD;
              OP_STQD: u = U_STQD;
              default: u = U_NOP;
            endcase
        endcase
    endcase
    return u;
  endfunction

  function automatic logic [VEC_W-1:0] vadd(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    for (int k = 0; k < NUM_WORDS; k++) r[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] vsub(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    for (int k = 0; k < NUM_WORDS; k++) r[32*k +: 32] = a[32*k +: 32] - b[32*k +: 32];
    return r;
  endfunction
endpackage

// File: rtl/spu_exec_unit.sv
// Combinational decode and ALU: rt write data, LS line and write, next pc and halt request.
module spu_exec_unit
  import spu_pkg::*;
(
  input  logic [31:7]      instr,
  input  logic [9:0]       pc,
  input  logic [VEC_W-1:0] ra_val,
  input  logic [VEC_W-1:0] rb_val,
  input  logic [VEC_W-1:0] rt_val,
  input  logic [VEC_W-1:0] ls_rdata,
  output logic [6:0]       ls_line,
  output logic             rt_we,
  output logic [VEC_W-1:0] rt_data,
  output logic             ls_we,
  output logic [VEC_W-1:0] ls_wdata,
  output logic [9:0]       next_pc,
  output logic             halt
);
  uop_e        uop;
  logic [9:0]  i10;
  logic [15:0] i16;

  always_comb begin
    uop      = decode({instr, 7'b0});
    i10      = instr[23:14];
    i16      = instr[22:7];
    // Offset is a multiple of 16, so line = EA[10:4] needs no carry from below bit 4.
    ls_line  = ra_val[106:100] + i10[6:0];
    rt_we    = 1'b0;
    rt_data  = '0;
    ls_we    = 1'b0;
    ls_wdata = rt_val;
    next_pc  = pc + 10'd1;
    halt     = 1'b0;
    case (uop)
      U_A:    begin rt_we = 1'b1; rt_data = vadd(ra_val, rb_val); end
      U_SF:   begin rt_we = 1'b1; rt_data = vsub(rb_val, ra_val); end
      U_AND:  begin rt_we = 1'b1; rt_data = ra_val & rb_val; end
      U_OR:   begin rt_we = 1'b1; rt_data = ra_val | rb_val; end
      U_XOR:  begin rt_we = 1'b1; rt_data = ra_val ^ rb_val; end
      U_STOP: begin halt = 1'b1; next_pc = pc; end
      U_IL:   begin rt_we = 1'b1; rt_data = {NUM_WORDS{{16{i16[15]}}, i16}}; end
      U_BR:   next_pc = pc + i16[9:0];
      U_BRZ:  if (rt_val[127:96] == 32'd0) next_pc = pc + i16[9:0];
      U_AI:   begin rt_we = 1'b1; rt_data = vadd(ra_val, {NUM_WORDS{{22{i10[9]}}, i10}}); end
      U_LQD:  begin rt_we = 1'b1; rt_data = ls_rdata; end
      U_STQD: ls_we = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/spu_top.sv
// SPU core top: imem, register file, local store, pc and halt state.
// Optional retired-instruction counter enabled by SPU_RETIRE_CNT_EN.
module spu_top
  import spu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [31:0]      instruction_in,
  input  logic [9:0]       instr_load_addr,
  input  logic             preload_en,
  input  logic [9:0]       preload_addr,
  input  logic [VEC_W-1:0] preload_values,
  input  logic             preload_LS_en,
  input  logic [6:0]       preload_LS_addr,
  input  logic [VEC_W-1:0] preload_LS_data,
  output logic [9:0]       pc,
  output logic             halted
`ifdef SPU_RETIRE_CNT_EN
  ,
  output logic [31:0]      retired_cnt
`endif
);
  logic [31:0]      imem   [IMEM_WORDS];
  logic [VEC_W-1:0] rf     [NUM_REGS];
  logic [VEC_W-1:0] ls_mem [LS_LINES];

  logic [31:0]      cur;
  logic [6:0]       ra_idx, rb_idx, rt_idx, ls_line;
  logic             run, rt_we, ls_we, halt;
  logic [VEC_W-1:0] rt_data, ls_wdata;
  logic [9:0]       next_pc;
  logic             unused;

  assign cur    = imem[pc];
  assign ra_idx = cur[RA_LSB +: 7];
  assign rb_idx = cur[RB_LSB +: 7];
  assign rt_idx = cur[RT_LSB +: 7];
  assign run    = rst && !halted;
  assign unused = ^preload_addr[9:7];

  spu_exec_unit u_exec (
    .instr    (cur[31:7]),
    .pc       (pc),
    .ra_val   (rf[ra_idx]),
    .rb_val   (rf[rb_idx]),
    .rt_val   (rf[rt_idx]),
    .ls_rdata (ls_mem[ls_line]),
    .ls_line  (ls_line),
    .rt_we    (rt_we),
    .rt_data  (rt_data),
    .ls_we    (ls_we),
    .ls_wdata (ls_wdata),
    .next_pc  (next_pc),
    .halt     (halt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc     <= next_pc;
      halted <= halt;
    end
  end

  always_ff @(posedge clk)
    if (load_en) imem[instr_load_addr] <= instruction_in;

  // Preload assignments come last so they override a core write to the same entry.
  always_ff @(posedge clk) begin
    if (run && rt_we) rf[rt_idx] <= rt_data;
    if (preload_en)   rf[preload_addr[6:0]] <= preload_values;
  end

  always_ff @(posedge clk) begin
    if (run && ls_we)  ls_mem[ls_line] <= ls_wdata;
    if (preload_LS_en) ls_mem[preload_LS_addr] <= preload_LS_data;
  end

`ifdef SPU_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                               retired_cnt <= '0;
    else if (run && retired_cnt != '1)      retired_cnt <= retired_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_spu_top.sv
// Bench for spu_top: directed programs, a vector table and a random program against a reference model.
module tb_spu_top;
  logic         clk = 1'b0;
  logic         rst, load_en, preload_en, preload_LS_en, halted;
  logic [31:0]  instruction_in;
  logic [9:0]   instr_load_addr, preload_addr, pc;
  logic [127:0] preload_values, preload_LS_data;
  logic [6:0]   preload_LS_addr;
`ifdef SPU_RETIRE_CNT_EN
  logic [31:0]  retired_cnt;
`endif

  always #5 clk = ~clk;

  spu_top dut (
    .clk(clk), .rst(rst), .load_en(load_en), .instruction_in(instruction_in),
    .instr_load_addr(instr_load_addr), .preload_en(preload_en), .preload_addr(preload_addr),
    .preload_values(preload_values), .preload_LS_en(preload_LS_en),
    .preload_LS_addr(preload_LS_addr), .preload_LS_data(preload_LS_data),
    .pc(pc), .halted(halted)
`ifdef SPU_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  localparam logic [10:0] T_A = 11'b00011000000, T_SF = 11'b00001000000, T_AND = 11'b00011000001;
  localparam logic [10:0] T_OR = 11'b00001000001, T_XOR = 11'b01001000001, T_NOP = 11'b01000000001;
  localparam logic [10:0] T_STOP = 11'b00000000000;
  localparam logic [8:0]  T_IL = 9'b010000001, T_BR = 9'b001100100, T_BRZ = 9'b001000000;
  localparam logic [7:0]  T_AI = 8'b00011100, T_LQD = 8'b00110100, T_STQD = 8'b00100100;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rr(input logic [10:0] op, input int rb, input int ra, input int rt);
    return {op, 7'(rb), 7'(ra), 7'(rt)};
  endfunction
  function automatic logic [31:0] ri10(input logic [7:0] op, input logic [9:0] i, input int ra, input int rt);
    return {op, i, 7'(ra), 7'(rt)};
  endfunction
  function automatic logic [31:0] ri16(input logic [8:0] op, input logic [15:0] i, input int rt);
    return {op, i, 7'(rt)};
  endfunction

  task automatic ld_imem(input int a, input logic [31:0] w);
    load_en = 1'b1; instr_load_addr = 10'(a); instruction_in = w; step(); load_en = 1'b0;
  endtask
  task automatic ld_reg(input int r, input logic [127:0] v);
    preload_en = 1'b1; preload_addr = 10'(r); preload_values = v; step(); preload_en = 1'b0;
  endtask
  task automatic ld_ls(input int l, input logic [127:0] v);
    preload_LS_en = 1'b1; preload_LS_addr = 7'(l); preload_LS_data = v; step(); preload_LS_en = 1'b0;
  endtask

  // Reference model state
  logic [31:0]  m_imem [1024];
  logic [127:0] m_rf   [128];
  logic [127:0] m_ls   [128];
  logic [9:0]   m_pc;
  logic         m_halt;

  function automatic logic [31:0] wd(input logic [127:0] v, input int k);
    return v[127-32*k -: 32];
  endfunction

  task automatic m_step();
    logic [31:0] w, ea, imm10, imm16;
    logic [127:0] a, b, t, res;
    logic [9:0] nxt;
    int ra, rb, rt;
    if (m_halt) return;
    w = m_imem[m_pc];
    rt = int'(w[6:0]); ra = int'(w[13:7]); rb = int'(w[20:14]);
    a = m_rf[ra]; b = m_rf[rb]; t = m_rf[rt];
    imm10 = {{22{w[23]}}, w[23:14]};
    imm16 = {{16{w[22]}}, w[22:7]};
    nxt = m_pc + 10'd1;
    res = '0;
    if (w[31:21] == T_A) begin
      for (int k = 0; k < 4; k++) res[127-32*k -: 32] = wd(a, k) + wd(b, k);
      m_rf[rt] = res;
    end else if (w[31:21] == T_SF) begin
      for (int k = 0; k < 4; k++) res[127-32*k -: 32] = wd(b, k) - wd(a, k);
      m_rf[rt] = res;
    end else if (w[31:21] == T_AND) m_rf[rt] = a & b;
    else if (w[31:21] == T_OR)   m_rf[rt] = a | b;
    else if (w[31:21] == T_XOR)  m_rf[rt] = a ^ b;
    else if (w[31:21] == T_NOP)  ;
    else if (w[31:21] == T_STOP) begin m_halt = 1'b1; nxt = m_pc; end
    else if (w[31:23] == T_IL)   m_rf[rt] = {4{imm16}};
    else if (w[31:23] == T_BR)   nxt = m_pc + w[16:7];
    else if (w[31:23] == T_BRZ)  begin if (wd(t, 0) == 0) nxt = m_pc + w[16:7]; end
    else if (w[31:24] == T_AI) begin
      for (int k = 0; k < 4; k++) res[127-32*k -: 32] = wd(a, k) + imm10;
      m_rf[rt] = res;
    end else if (w[31:24] == T_LQD || w[31:24] == T_STQD) begin
      ea = wd(a, 0) + (imm10 << 4);
      if (w[31:24] == T_LQD) m_rf[rt] = m_ls[ea[10:4]];
      else                   m_ls[ea[10:4]] = t;
    end
    m_pc = nxt;
  endtask

  typedef struct {
    logic [31:0]  ins;
    logic [127:0] exp_rt;
    logic [9:0]   exp_pc;
  } vec_t;

  localparam logic [127:0] VA = 128'h00000001_FFFFFFFF_7FFFFFFF_12345678;
  localparam logic [127:0] VB = 128'h00000002_00000001_00000001_11111111;
  localparam logic [127:0] VC = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  vec_t tbl [11];

  initial begin
    rst = 1'b0; load_en = 1'b0; preload_en = 1'b0; preload_LS_en = 1'b0;
    instruction_in = '0; instr_load_addr = '0; preload_addr = '0; preload_values = '0;
    preload_LS_addr = '0; preload_LS_data = '0;

    // Reset state
    step();
    chk("reset pc", pc, 10'd0);
    chk("reset halted", halted, 1'b0);

    // Load/add/store program
    ld_ls(16, {4{32'h1}}); ld_ls(32, {4{32'h2}}); ld_ls(48, {4{32'h3}}); ld_ls(64, {4{32'h4}});
    ld_reg(0, '0);
    ld_imem(0, ri10(T_LQD, 10'd16, 0, 3));
    ld_imem(1, ri10(T_LQD, 10'd32, 0, 4));
    ld_imem(2, rr(T_A, 4, 3, 5));
    ld_imem(3, ri10(T_STQD, 10'd80, 0, 5));
    ld_imem(4, 32'h0);
    chk("pc held in reset", pc, 10'd0);
    rst = 1'b1;
    step();
    chk("lqd r3", dut.rf[3], {4{32'h1}});
    chk("pc after 1", pc, 10'd1);
    step(); chk("lqd r4", dut.rf[4], {4{32'h2}});
    step(); chk("a r5", dut.rf[5], {4{32'h3}});
    step(); chk("stqd ls80", dut.ls_mem[80], {4{32'h3}});
    step(); chk("stop A halted", halted, 1'b1); chk("stop A pc", pc, 10'd4);
`ifdef SPU_RETIRE_CNT_EN
    step(); chk("retired_cnt", retired_cnt, 32'd5);
`endif

    // il / sf / brz program with stop at 5
    rst = 1'b0; step();
    ld_reg(9, {4{32'hA5A5A5A5}}); ld_reg(10, '0);
    ld_imem(0, ri16(T_IL, 16'hFFFF, 1));
    ld_imem(1, rr(T_SF, 1, 1, 2));
    ld_imem(2, ri16(T_BRZ, 16'd2, 2));
    ld_imem(3, ri16(T_IL, 16'd7, 9));
    ld_imem(4, ri16(T_IL, 16'd1, 10));
    ld_imem(5, 32'h0);
    rst = 1'b1;
    step(); chk("il r1", dut.rf[1], {4{32'hFFFFFFFF}});
    step(); chk("sf r2", dut.rf[2], 128'h0); chk("pc 2", pc, 10'd2);
    step(); chk("brz taken pc", pc, 10'd4);
    step(); chk("il r10", dut.rf[10], {4{32'h1}}); chk("pc 5", pc, 10'd5);
    step(); chk("stop B halted", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold pc %0d", i), pc, 10'd5);
      chk($sformatf("hold halted %0d", i), halted, 1'b1);
    end
    chk("skipped r9", dut.rf[9], {4{32'hA5A5A5A5}});
    rst = 1'b0; step();
    chk("rerst pc", pc, 10'd0);
    chk("rerst halted", halted, 1'b0);
    chk("ls80 retained", dut.ls_mem[80], {4{32'h3}});
    chk("r5 retained", dut.rf[5], {4{32'h3}});

    // Preload/core collisions and undefined opcode
    ld_imem(0, ri16(T_IL, 16'd5, 7));
    ld_imem(1, 32'hFFFFFFFF);
    ld_imem(2, ri10(T_STQD, 10'd5, 0, 7));
    ld_imem(3, 32'h0);
    rst = 1'b1;
    preload_en = 1'b1; preload_addr = {3'b101, 7'd7}; preload_values = VC;
    step(); preload_en = 1'b0;
    chk("collide r7", dut.rf[7], VC); chk("collide pc", pc, 10'd1);
    step(); chk("undef pc", pc, 10'd2); chk("undef r7", dut.rf[7], VC); chk("undef halted", halted, 1'b0);
    preload_LS_en = 1'b1; preload_LS_addr = 7'd5; preload_LS_data = VA;
    step(); preload_LS_en = 1'b0;
    chk("collide ls5", dut.ls_mem[5], VA);
    step(); chk("stop C halted", halted, 1'b1);

    // Single-instruction vector table: r1=VA, r2=VB, r3=VC, destination r3
    tbl[0]  = '{rr(T_A, 2, 1, 3),   128'h00000003_00000000_80000000_23456789, 10'd1};
    tbl[1]  = '{rr(T_SF, 2, 1, 3),  128'h00000001_00000002_80000002_FEDCBA99, 10'd1};
    tbl[2]  = '{rr(T_AND, 2, 1, 3), 128'h00000000_00000001_00000001_10101010, 10'd1};
    tbl[3]  = '{rr(T_OR, 2, 1, 3),  128'h00000003_FFFFFFFF_7FFFFFFF_13355779, 10'd1};
    tbl[4]  = '{rr(T_XOR, 2, 1, 3), 128'h00000003_FFFFFFFE_7FFFFFFE_03254769, 10'd1};
    tbl[5]  = '{ri10(T_AI, 10'h3FE, 1, 3), 128'hFFFFFFFF_FFFFFFFD_7FFFFFFD_12345676, 10'd1};
    tbl[6]  = '{ri16(T_IL, 16'h8001, 3), {4{32'hFFFF8001}}, 10'd1};
    tbl[7]  = '{rr(T_NOP, 2, 1, 3), VC, 10'd1};
    tbl[8]  = '{32'hFFFFFFFF, VC, 10'd1};
    tbl[9]  = '{ri16(T_BR, 16'h03FF, 3), VC, 10'd1023};
    tbl[10] = '{ri16(T_BRZ, 16'd5, 1), VC, 10'd1};
    for (int i = 0; i < 11; i++) begin
      rst = 1'b0; step();
      ld_reg(1, VA); ld_reg(2, VB); ld_reg(3, VC);
      ld_imem(0, tbl[i].ins);
      rst = 1'b1; step();
      chk($sformatf("vec%0d rt", i), dut.rf[3], tbl[i].exp_rt);
      chk($sformatf("vec%0d pc", i), pc, tbl[i].exp_pc);
    end

    // Random program against the reference model
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w, rnd;
      int k;
      k = (($urandom_range(0, 40) == 0) ? 13 : $urandom_range(0, 12));
      rnd = $urandom;
      case (k)
        0:  w = rr(T_A,   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        1:  w = rr(T_SF,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        2:  w = rr(T_AND, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        3:  w = rr(T_OR,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        4:  w = rr(T_XOR, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        5:  w = rr(T_NOP, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        6:  w = ri10(T_AI,   rnd[9:0], $urandom_range(0, 7), $urandom_range(0, 7));
        7:  w = ri10(T_LQD,  rnd[9:0], $urandom_range(0, 7), $urandom_range(0, 7));
        8:  w = ri10(T_STQD, rnd[9:0], $urandom_range(0, 7), $urandom_range(0, 7));
        9:  w = ri16(T_IL,  rnd[15:0], $urandom_range(0, 7));
        10: w = ri16(T_BR,  rnd[15:0], $urandom_range(0, 7));
        11: w = ri16(T_BRZ, rnd[15:0], $urandom_range(0, 7));
        12: w = {8'hFF, rnd[23:0]};
        default: w = 32'h0;
      endcase
      m_imem[i] = w;
      load_en = 1'b1; instr_load_addr = 10'(i); instruction_in = w;
      preload_LS_en = (i < 128);
      if (i < 128) begin
        m_ls[i] = {$urandom, $urandom, $urandom, $urandom};
        if (i % 4 == 0) m_ls[i][127:96] = 32'(i % 7);
        preload_LS_addr = 7'(i); preload_LS_data = m_ls[i];
      end
      preload_en = (i < 8);
      if (i < 8) begin
        m_rf[i] = {$urandom, $urandom, $urandom, $urandom};
        if (i % 3 == 0) m_rf[i][127:96] = 32'd0;
        preload_addr = 10'(i); preload_values = m_rf[i];
      end
      step();
    end
    load_en = 1'b0; preload_en = 1'b0; preload_LS_en = 1'b0;
    m_pc = '0; m_halt = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 400; c++) begin
      m_step();
      step();
      chk($sformatf("rand pc c%0d", c), pc, m_pc);
      chk($sformatf("rand halted c%0d", c), halted, m_halt);
    end
    for (int r = 0; r < 8; r++) chk($sformatf("rand r%0d", r), dut.rf[r], m_rf[r]);
    for (int l = 0; l < 128; l++) chk($sformatf("rand ls%0d", l), dut.ls_mem[l], m_ls[l]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
